// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response, branch redirect,
// and the decoder-facing valid/ready instruction stream.
interface instr_fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [6:0]      opcode;
    logic            instr_illegal;

    // master is the fetch queue itself; slave is the memory/decoder/branch side
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, instr_illegal,
        input  imem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, opcode, instr_illegal,
        output imem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetcher with a credit-limited FIFO and redirect flush.
// Optional macro ILLEGAL_OPCODE_CHECK_EN enables the head-opcode legality flag.
module instr_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_queue_if.master bus
);
    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] fifo_instr [DEPTH];
    logic [XLEN-1:0] fifo_pc    [DEPTH];

    logic [CW:0]     used;
    logic            req;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic [XLEN-1:0] head_instr;
    logic            unused_redirect_lo;

    // Credits count the outstanding response so the FIFO can never overflow
    assign head_valid = (count != '0);
    assign used       = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign req        = !rst && !bus.redirect_valid && (used < DEPTH_W);
    assign pop        = head_valid && bus.instr_ready;
    assign push       = inflight && !bus.redirect_valid;
    assign unused_redirect_lo = ^bus.redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= req;
            if (req) begin
                pc          <= pc + XLEN'(4);
                inflight_pc <= pc;
            end
            // A redirect drops every buffered entry; a same-cycle pop was already taken
            if (bus.redirect_valid) begin
                pc     <= {bus.redirect_pc[XLEN-1:2], 2'b00};
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]    <= inflight_pc;
        end
    end

    assign head_instr    = head_valid ? fifo_instr[rd_ptr] : '0;
    assign bus.imem_req  = req;
    assign bus.imem_addr = pc;
    assign bus.instr_valid = head_valid;
    assign bus.instr     = head_instr;
    assign bus.instr_pc  = head_valid ? fifo_pc[rd_ptr] : '0;
    assign bus.opcode    = head_instr[6:0];

`ifdef ILLEGAL_OPCODE_CHECK_EN
    logic legal;

    // R, I-ALU, load, store and branch are the only opcodes the decoder handles
    always_comb begin
        legal = 1'b0;
        case (head_instr[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign bus.instr_illegal = head_valid && !legal;
`else
    assign bus.instr_illegal = 1'b0;
`endif
endmodule
